// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry controller.
// Holds the FSM state type, keypad / pushbutton codes, ALU op
// encodings, register load-mode encodings and key decode helpers.
package calc_pkg;

   typedef enum logic [2:0] {
      ST_ENTRY_A,
      ST_OP_WAIT,
      ST_ENTRY_B,
      ST_EXECUTE,
      ST_RESULT,
      ST_ERROR
   } state_t;

   localparam logic [3:0] KEY_RESET_ALL = 4'hA;
   localparam logic [3:0] KEY_ADD       = 4'hB;
   localparam logic [3:0] KEY_CLEAR     = 4'hC;
   localparam logic [3:0] KEY_SUB       = 4'hD;
   localparam logic [3:0] KEY_MUL       = 4'hE;
   localparam logic [3:0] KEY_EQ        = 4'hF;

   localparam logic [1:0] PB_BACK = 2'b00;
   localparam logic [1:0] PB_MS   = 2'b01;
   localparam logic [1:0] PB_MR   = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_MUL = 2'b10;

   // entry register control modes driven on pushbuttons
   localparam logic [1:0] PBS_BACK = 2'b00;
   localparam logic [1:0] PBS_LOAD = 2'b10;

   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

   function automatic logic is_op(input logic [3:0] k);
      return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
   endfunction

   function automatic logic [1:0] key_to_op(input logic [3:0] k);
      logic [1:0] op;
      case (k)
         KEY_SUB: op = ALU_SUB;
         KEY_MUL: op = ALU_MUL;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/calc_alu_timeout.sv
// ALU response timeout: loadable down-counter with terminal-count flag.
// Ports:
//   clock       system clock
//   reset       synchronous active-high reset
//   load        level; while high the counter is held at load_value
//   load_value  reload value
//   expired     high while the counter sits at zero
// The counter stops at zero; the owner qualifies expired with its state.
module calc_alu_timeout #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/calc_entry_controller.sv
// Calculator entry sequencer. Turns debounced keypad / pushbutton events
// into controls for the 3-digit BCD entry register, holds memory and
// operand A, and runs the req/ack handshake with the arithmetic unit.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   key_valid, key_code          keypad event (0-9 digit, A-F commands)
//   pb_valid, pb_code            pushbutton event (back, MS, MR)
//   display_value                current entry register contents, BCD
//   shift_enable                 low for one cycle clears the register
//   number, clean_signal         digit insert
//   push_button_signal,
//   pushbuttons, load_value      backspace (00) or parallel load (10)
//   alu_req, alu_op,
//   operand_a, operand_b         ALU request, held until alu_ack
//   alu_ack, alu_result,
//   alu_error                    ALU response
//   error                        high while in ERROR
//
// state      | meaning
// -----------+----------------------------------------------------
// ENTRY_A    | entering first operand
// OP_WAIT    | operator chosen, waiting for first digit of operand B
// ENTRY_B    | entering second operand
// EXECUTE    | request outstanding to ALU
// RESULT     | ALU result loaded into register
// ERROR      | ALU error or timeout; only C / A leave
module calc_entry_controller
   import calc_pkg::*;
#(
   parameter int MAX_DIGITS  = 3,
   parameter int ALU_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        pb_valid,
   input  logic [1:0]  pb_code,
   input  logic [11:0] display_value,
   output logic        shift_enable,
   output logic [3:0]  number,
   output logic        clean_signal,
   output logic        push_button_signal,
   output logic [1:0]  pushbuttons,
   output logic [11:0] load_value,
   output logic        alu_req,
   output logic [1:0]  alu_op,
   output logic [11:0] operand_a,
   output logic [11:0] operand_b,
   input  logic        alu_ack,
   input  logic [11:0] alu_result,
   input  logic        alu_error,
   output logic        error
);

   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int TW = $clog2(ALU_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DIGITS);
   // reload one short so alu_req stays high exactly ALU_TIMEOUT cycles
   localparam logic [TW-1:0] TMO_LOAD = TW'(ALU_TIMEOUT - 1);

   state_t          state;
   logic [CW-1:0]   count;
   logic [11:0]     memory;
   logic            ins_pend;
   logic [3:0]      ins_digit;
   logic            reset_all;
   logic            tmo_load;
   logic            tmo_expired;

   assign reset_all = key_valid && (key_code == KEY_RESET_ALL);
   assign tmo_load  = (state != ST_EXECUTE);

   calc_alu_timeout #(
      .WIDTH (TW)
   ) u_timeout (
      .clock      (clock),
      .reset      (reset),
      .load       (tmo_load),
      .load_value (TMO_LOAD),
      .expired    (tmo_expired)
   );

   always_ff @(posedge clock) begin
      // reset-all is a full reset from the keypad, memory included
      if (reset || reset_all) begin
         state              <= ST_ENTRY_A;
         shift_enable       <= 1'b0;
         number             <= '0;
         clean_signal       <= 1'b0;
         push_button_signal <= 1'b0;
         pushbuttons        <= PBS_BACK;
         load_value         <= '0;
         alu_req            <= 1'b0;
         alu_op             <= ALU_ADD;
         operand_a          <= '0;
         operand_b          <= '0;
         error              <= 1'b0;
         memory             <= '0;
         count              <= '0;
         ins_pend           <= 1'b0;
         ins_digit          <= '0;
      end else begin
         shift_enable       <= 1'b1;
         clean_signal       <= 1'b0;
         push_button_signal <= 1'b0;

         if (ins_pend) begin
            // second half of clear-then-insert; events this cycle are dropped
            clean_signal <= 1'b1;
            number       <= ins_digit;
            ins_pend     <= 1'b0;
         end else if (state == ST_EXECUTE) begin
            if (alu_ack) begin
               alu_req <= 1'b0;
               if (alu_error) begin
                  state <= ST_ERROR;
                  error <= 1'b1;
               end else begin
                  load_value         <= alu_result;
                  push_button_signal <= 1'b1;
                  pushbuttons        <= PBS_LOAD;
                  state              <= ST_RESULT;
               end
            end else if (tmo_expired) begin
               alu_req <= 1'b0;
               state   <= ST_ERROR;
               error   <= 1'b1;
            end
         end else if (key_valid) begin
            if (is_digit(key_code)) begin
               case (state)
                  ST_ENTRY_A, ST_ENTRY_B: begin
                     if (count < CNT_MAX) begin
                        clean_signal <= 1'b1;
                        number       <= key_code;
                        count        <= count + CW'(1);
                     end
                  end
                  ST_OP_WAIT, ST_RESULT: begin
                     shift_enable <= 1'b0;
                     ins_pend     <= 1'b1;
                     ins_digit    <= key_code;
                     count        <= CW'(1);
                     state        <= (state == ST_OP_WAIT) ? ST_ENTRY_B : ST_ENTRY_A;
                  end
                  default: ;
               endcase
            end else if (key_code == KEY_CLEAR) begin
               shift_enable <= 1'b0;
               count        <= '0;
               if (state == ST_ERROR) begin
                  state <= ST_ENTRY_A;
                  error <= 1'b0;
               end
            end else if (is_op(key_code)) begin
               case (state)
                  ST_ENTRY_A, ST_RESULT: begin
                     operand_a <= display_value;
                     alu_op    <= key_to_op(key_code);
                     count     <= '0;
                     state     <= ST_OP_WAIT;
                  end
                  ST_ENTRY_B, ST_OP_WAIT: alu_op <= key_to_op(key_code);
                  default: ;
               endcase
            end else if ((key_code == KEY_EQ) && (state == ST_ENTRY_B)) begin
               operand_b <= display_value;
               alu_req   <= 1'b1;
               state     <= ST_EXECUTE;
            end
         end else if (pb_valid && (state != ST_ERROR)) begin
            case (pb_code)
               PB_BACK: begin
                  if (((state == ST_ENTRY_A) || (state == ST_ENTRY_B)) && (count != '0)) begin
                     push_button_signal <= 1'b1;
                     pushbuttons        <= PBS_BACK;
                     count              <= count - CW'(1);
                  end
               end
               PB_MS: memory <= display_value;
               PB_MR: begin
                  load_value         <= memory;
                  push_button_signal <= 1'b1;
                  pushbuttons        <= PBS_LOAD;
                  count              <= CNT_MAX;
                  if (state == ST_OP_WAIT) state <= ST_ENTRY_B;
                  if (state == ST_RESULT)  state <= ST_ENTRY_A;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/calc_entry_controller.md
Name: calc_entry_controller

Overview:
Sequences the calculator's 3-digit BCD entry register from debounced keypad and pushbutton events. Drives the register's shift/clear, digit-insert, backspace and parallel-load controls. Owns the memory (MS/MR) value and operand A, and runs a req/ack transaction with the arithmetic unit. Sits between the input debouncers and the BCD entry register / ALU.

Parameters:
MAX_DIGITS, 3, digits accepted per operand; further digits are dropped
ALU_TIMEOUT, 255, cycles to wait for alu_ack before entering ERROR

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
key_valid  input  1  one-cycle pulse, keypad event
key_code  input  4  0-9 digit, A reset-all, B add, C clear, D subtract, E multiply, F equals
pb_valid  input  1  one-cycle pulse, pushbutton event
pb_code  input  2  00 backspace, 01 memory store, 10 memory recall, 11 ignored
display_value  input  12  current register contents {Q2,Q1,Q0}, BCD
shift_enable  output  1  register enable; low for one cycle = clear register
number  output  4  digit to insert
clean_signal  output  1  pulse: insert number
push_button_signal  output  1  pulse: backspace or parallel load
pushbuttons  output  2  00 backspace, 10 load
load_value  output  12  value for parallel load (memory or ALU result)
alu_req  output  1  held high until alu_ack
alu_op  output  2  00 add, 01 sub, 10 mul
operand_a  output  12  latched first operand
operand_b  output  12  latched second operand
alu_ack  input  1  one-cycle pulse, result valid
alu_result  input  12  BCD result
alu_error  input  1  qualified by alu_ack; overflow/negative
error  output  1  high in ERROR state

Behaviour:
- Reset: state ENTRY_A; shift_enable=0 during reset, 1 on first cycle after; all pulses 0; number=0, pushbuttons=00; load_value, operand_a, operand_b, memory, digit count = 0; alu_req=0, alu_op=00, error=0.
- States: ENTRY_A, OP_WAIT, ENTRY_B, EXECUTE, RESULT, ERROR.
- All register-control outputs registered: 1-cycle latency from key_valid/pb_valid to pulse.
- Digit (0-9) in ENTRY_A/ENTRY_B: if count<MAX_DIGITS, pulse clean_signal with number=key_code, count++; else drop. In OP_WAIT/RESULT: clear register (shift_enable=0 one cycle), then insert digit next cycle, count=1, go ENTRY_B (OP_WAIT) or ENTRY_A (RESULT).
- Operator B/D/E in ENTRY_A or RESULT: operand_a<=display_value, alu_op set, go OP_WAIT. In ENTRY_B: replace alu_op only. In OP_WAIT: replace alu_op.
- Equals F in ENTRY_B: operand_b<=display_value, alu_req=1, go EXECUTE. F elsewhere: ignored.
- EXECUTE: all key/pb events ignored except A. On alu_ack: alu_req=0; if alu_error go ERROR, else load_value<=alu_result, pulse push_button_signal with pushbuttons=10, go RESULT. Timeout counter reaching ALU_TIMEOUT -> ERROR, alu_req=0.
- C (clear): any state except EXECUTE: shift_enable=0 one cycle, count=0; ERROR->ENTRY_A; OP_WAIT stays; others stay. Memory/operand_a kept.
- A (reset-all): any state: same effect as reset but memory also cleared, one cycle shift_enable=0.
- Backspace (pb 00) in ENTRY_A/ENTRY_B with count>0: pulse push_button_signal, pushbuttons=00, count--; count=0: ignored.
- MS (pb 01): memory<=display_value, any state except EXECUTE/ERROR; no register activity.
- MR (pb 10) in ENTRY_A/ENTRY_B/OP_WAIT/RESULT: load_value<=memory, load pulse, count=MAX_DIGITS; OP_WAIT->ENTRY_B, RESULT->ENTRY_A.
- ERROR: error=1; only C or A leave (to ENTRY_A).
- Simultaneous key_valid and pb_valid: key wins, pb dropped. Never more than one of clean_signal/push_button_signal/shift_enable-low in a cycle.
- Reset mid-EXECUTE: alu_req drops the same edge; late alu_ack ignored.

Decomposition:
- Package calc_pkg: state enum, key-code constants (KEY_RESET_ALL=A, KEY_ADD=B, KEY_CLEAR=C, KEY_SUB=D, KEY_MUL=E, KEY_EQ=F), pb constants (PB_BACK, PB_MS, PB_MR), alu_op encodings.
- One sub-module natural: calc_alu_timeout (loadable down-counter with expiry flag).

Test Plan:
- Reset, keys 1,2,3,4 -> three clean_signal pulses (1,2,3), fourth dropped; display 123.
- 1,2, backspace x3 -> one clean pulse per digit, two backspace pulses (pushbuttons=00), third ignored.
- 1,2,B,3,F with alu_ack after 5 cycles, result 015 -> operand_a=012, operand_b=003, alu_op=00, alu_req held 5 cycles, load pulse with load_value=015, state RESULT.
- 7,MS,A,MR -> memory=007 before A, A clears memory, MR loads 000.
- 9,D,F -> F ignored in OP_WAIT, no alu_req; 9,E,5,F with no ack -> ERROR after 255 cycles, error=1; digit ignored; C -> ENTRY_A, error=0.
- key_valid and pb_valid (MR) same cycle with key 4 -> only clean_signal number=4; reset asserted mid-EXECUTE -> alu_req=0 next edge, all outputs at reset values.
